term_char_writer: RTL and testbench
===================================

Name: term_char_writer

Overview:
- Receiving end of the keyboard-to-terminal character interface: accepts one character per write strobe from the input side and owns the terminal cursor.
- Translates printable characters, newline, backspace and a clear request into single-port writes to the VGA character RAM.
- Sits between the PS2 input path and the VGA character buffer; exports the cursor position for display.

Parameters:
- COLS, 32, characters per row
- ROWS, 7, rows on screen
- ADDR_W, 8, character RAM address width; must satisfy ROWS*COLS <= 2^ADDR_W

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- char_in  in  8  ASCII character, sampled when accepted
- write_req  in  1  character strobe; accepted in any cycle where write_req=1 and ready=1
- clear_req  in  1  clear-screen strobe; accepted when ready=1
- ready  out  1  block can accept a request this cycle
- mem_we  out  1  character RAM write enable, one-cycle pulse per write
- mem_addr  out  ADDR_W  RAM address = row*COLS + col
- mem_data  out  8  RAM write data
- cursor_row  out  8  current cursor row, 0..ROWS-1
- cursor_col  out  8  current cursor column, 0..COLS-1

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE, ready=1, mem_we=0, mem_addr=0, mem_data=0, cursor_row=0, cursor_col=0. Reset aborts any operation in progress, including a clear in progress.
- States:
  - IDLE: ready=1.
  - BUSY: one cycle, ready=0.
  - CLEAR: ready=0.
- Requests arriving while ready=0 are dropped, not queued.
- If clear_req and write_req are both 1 in an accepting cycle, clear_req wins and the character is dropped.
- Accepted write_req in cycle N: IDLE->BUSY. The command takes effect in cycle N+1, then BUSY->IDLE, so ready=1 again in N+2.
  - char 0x00: no write, cursor unchanged.
  - 0x0A (newline): no write. col=0. row=row+1, or row=0 if row=ROWS-1.
  - 0x08 (backspace):
    - If col>0: col=col-1, write 0x20 at the new position.
    - If col=0 and row>0: row=row-1, col=COLS-1, write 0x20 there.
    - At (0,0): no write, cursor unchanged.
  - Any other value: write char at the current (row,col), then advance the cursor.
    - If col<COLS-1: col+1.
    - Else: col=0, and row+1, or row=0 if row=ROWS-1.
    - No scrolling; wrap past the last cell overwrites from the top.
- Write timing: mem_we=1 in cycle N+1 only. mem_addr/mem_data are the pre-advance address for normal chars and the post-retreat address for backspace. The cursor outputs show the new position from cycle N+1.
- Accepted clear_req in cycle N: IDLE->CLEAR.
  - Cycles N+1 .. N+ROWS*COLS: mem_we=1, mem_data=0x20, mem_addr = 0,1,…,ROWS*COLS-1 ascending.
  - The cursor is set to (0,0) in cycle N+1.
  - CLEAR->IDLE after the last address; ready=1 in cycle N+ROWS*COLS+1.
- Arithmetic: compute the address as row*COLS+col at ADDR_W bits with no truncation for legal parameters. Cursor counters never leave their ranges.
- mem_addr/mem_data hold their last values when mem_we=0.

Test Plan:
- Reset, then idle 5 cycles -> ready=1, mem_we=0, cursor (0,0), mem_addr=0 throughout.
- write_req with 0x41 at (0,0) in cycle N -> cycle N+1: mem_we=1, addr=0, data=0x41, cursor (0,1), ready=0; cycle N+2: ready=1. A second write_req held high in N+1 produces no extra write.
- Wrap: 32 printable chars, then 0x0A, then backspace -> 32 writes at addr 0..31; cursor after the 32nd char is (1,0), after newline (2,0), after backspace (1,31) with a write of 0x20 at addr 63. Then 0x08 typed at (0,0) after reset -> no write.
- Last cell: cursor at (6,31), char 0x5A -> write addr 223, data 0x5A, cursor (0,0).
- clear_req and write_req(0x41) in the same cycle -> 224 writes of 0x20, addr 0..223 consecutive, ready=0 for 224 cycles, cursor (0,0); the 0x41 is never written.
- Assert resetn=0 midway through a clear (after addr 100) -> all outputs return to reset values immediately. The first request after release is accepted normally.

Source files
------------

// File: rtl/term_char_writer_if.sv
// ---------------------------------------------------------------------------
// term_char_writer_if
//   Request-side interface of the terminal character writer.
//
//   Handshake: a request (write_req or clear_req) is accepted in a cycle
//   where it is 1 and ready is 1; there is no queueing, so a request raised
//   while ready=0 is dropped. char_in is only sampled in the accepting
//   cycle. If both strobes are accepted together, clear_req wins.
//
//   Signals
//     char_in    master->slave  8-bit ASCII character
//     write_req  master->slave  character strobe
//     clear_req  master->slave  clear-screen strobe
//     ready      slave->master  writer can accept a request this cycle
// ---------------------------------------------------------------------------
interface term_char_writer_if;
    logic [7:0] char_in;
    logic       write_req;
    logic       clear_req;
    logic       ready;

    modport master (output char_in, output write_req, output clear_req, input ready);
    modport slave  (input char_in, input write_req, input clear_req, output ready);
endinterface

// File: rtl/term_char_writer.sv
// ---------------------------------------------------------------------------
// term_char_writer
//   Owns the terminal cursor and turns accepted characters into single-port
//   writes to the VGA character RAM: printable characters, newline,
//   backspace, and a full-screen clear that sweeps every cell with spaces.
//
//   Ports
//     clock       system clock, rising edge
//     resetn      asynchronous active-low reset
//     req         request interface (slave side): char_in/write_req/
//                 clear_req in, ready out
//     mem_we      character RAM write enable, one-cycle pulse per write
//     mem_addr    character RAM address = row*COLS + col
//     mem_data    character RAM write data
//     cursor_row  current cursor row, 0..ROWS-1
//     cursor_col  current cursor column, 0..COLS-1
//     fsm_state   current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module term_char_writer #(
    parameter int COLS   = 32,
    parameter int ROWS   = 7,
    parameter int ADDR_W = 8
) (
    input  logic                clock,
    input  logic                resetn,
    term_char_writer_if.slave   req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_data,
    output logic [7:0]          cursor_row,
    output logic [7:0]          cursor_col,
    output logic [1:0]          fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

    logic [1:0] state;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] r, input logic [7:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign req.ready = (state == S_IDLE);
    assign fsm_state = state;

    // The command is applied on the accepting edge, so its write pulse and
    // the new cursor appear in the following cycle, which is also the single
    // BUSY cycle that holds ready low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req.clear_req) begin
                        state      <= S_CLEAR;
                        mem_we     <= 1'b1;
                        mem_addr   <= '0;
                        mem_data   <= CH_SPACE;
                        cursor_row <= '0;
                        cursor_col <= '0;
                    end else if (req.write_req) begin
                        state <= S_BUSY;
                        case (req.char_in)
                            CH_NUL: begin
                            end
                            CH_NL: begin
                                cursor_col <= '0;
                                cursor_row <= (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
                            end
                            CH_BS: begin
                                // Backspace blanks the cell it retreats onto.
                                if (cursor_col != 8'd0) begin
                                    cursor_col <= cursor_col - 8'd1;
                                    mem_we     <= 1'b1;
                                    mem_addr   <= addr_of(cursor_row, cursor_col - 8'd1);
                                    mem_data   <= CH_SPACE;
                                end else if (cursor_row != 8'd0) begin
                                    cursor_row <= cursor_row - 8'd1;
                                    cursor_col <= LAST_COL;
                                    mem_we     <= 1'b1;
                                    mem_addr   <= addr_of(cursor_row - 8'd1, LAST_COL);
                                    mem_data   <= CH_SPACE;
                                end
                            end
                            default: begin
                                mem_we   <= 1'b1;
                                mem_addr <= addr_of(cursor_row, cursor_col);
                                mem_data <= req.char_in;
                                if (cursor_col != LAST_COL) begin
                                    cursor_col <= cursor_col + 8'd1;
                                end else begin
                                    // No scrolling: past the last cell we wrap to the top.
                                    cursor_col <= '0;
                                    cursor_row <= (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
                                end
                            end
                        endcase
                    end
                end
                S_BUSY: begin
                    state <= S_IDLE;
                end
                S_CLEAR: begin
                    // mem_addr doubles as the sweep counter; mem_data stays 0x20.
                    if (mem_addr == LAST_ADDR) begin
                        state <= S_IDLE;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_term_char_writer.sv
module tb_term_char_writer;

    logic       clock;
    logic       resetn;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] cursor_row;
    logic [7:0] cursor_col;
    logic [1:0] fsm_state;

    int checks;
    int failures;

    term_char_writer_if bus ();

    term_char_writer #(.COLS(32), .ROWS(7), .ADDR_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (bus.slave),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        bus.write_req = 1'b0;
        bus.clear_req = 1'b0;
        bus.char_in   = 8'h00;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // driver: wait (bounded) for ready, present one char for one cycle.
    // Returns in the cycle after acceptance.
    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL send_wait_ready: ready=%b after %0d cycles, required 1", bus.ready, n);
        end
        bus.write_req = 1'b1;
        bus.char_in   = c;
        tick();
        bus.write_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.ready !== 1'b1 || mem_we !== 1'b0 || cursor_row !== 8'd0 ||
                cursor_col !== 8'd0 || mem_addr !== 8'd0 || mem_data !== 8'd0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: ready=%b we=%b row=%0d col=%0d addr=%0d data=%h, required 1 0 0 0 0 00",
                         i, bus.ready, mem_we, cursor_row, cursor_col, mem_addr, mem_data);
            end
            tick();
        end
    endtask

    task automatic test_single_write();
        do_reset();
        bus.write_req = 1'b1;
        bus.char_in   = 8'h41;
        tick();
        // cycle N+1; keep write_req high with another char, it must be dropped
        bus.char_in = 8'h42;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_data !== 8'h41 ||
            cursor_row !== 8'd0 || cursor_col !== 8'd1 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL single_write: we=%b addr=%0d data=%h row=%0d col=%0d ready=%b, required 1 0 41 0 1 0",
                     mem_we, mem_addr, mem_data, cursor_row, cursor_col, bus.ready);
        end
        tick();
        bus.write_req = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || bus.ready !== 1'b1 || cursor_col !== 8'd1 ||
            mem_addr !== 8'd0 || mem_data !== 8'h41) begin
            failures++;
            $display("FAIL single_after: we=%b ready=%b col=%0d addr=%0d data=%h, required 0 1 1 0 41",
                     mem_we, bus.ready, cursor_col, mem_addr, mem_data);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || cursor_col !== 8'd1 || mem_data !== 8'h41) begin
            failures++;
            $display("FAIL single_dropped: we=%b col=%0d data=%h, required 0 1 41",
                     mem_we, cursor_col, mem_data);
        end
    endtask

    task automatic test_null_char();
        // cursor is at (0,1) from the previous test
        send_char(8'h00);
        checks++;
        if (mem_we !== 1'b0 || cursor_row !== 8'd0 || cursor_col !== 8'd1 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL null_char: we=%b row=%0d col=%0d ready=%b, required 0 0 1 0",
                     mem_we, cursor_row, cursor_col, bus.ready);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            c = 8'h41 + 8'(i % 26);
            send_char(c);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 8'(i) || mem_data !== c) begin
                failures++;
                $display("FAIL wrap_write[%0d]: we=%b addr=%0d data=%h, required 1 %0d %h",
                         i, mem_we, mem_addr, mem_data, i, c);
            end
        end
        checks++;
        if (cursor_row !== 8'd1 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL wrap_cursor: row=%0d col=%0d, required 1 0", cursor_row, cursor_col);
        end
        send_char(8'h0A);
        checks++;
        if (mem_we !== 1'b0 || cursor_row !== 8'd2 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL newline: we=%b row=%0d col=%0d, required 0 2 0", mem_we, cursor_row, cursor_col);
        end
        send_char(8'h08);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd63 || mem_data !== 8'h20 ||
            cursor_row !== 8'd1 || cursor_col !== 8'd31) begin
            failures++;
            $display("FAIL bs_row_wrap: we=%b addr=%0d data=%h row=%0d col=%0d, required 1 63 20 1 31",
                     mem_we, mem_addr, mem_data, cursor_row, cursor_col);
        end
        send_char(8'h08);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd62 || mem_data !== 8'h20 ||
            cursor_row !== 8'd1 || cursor_col !== 8'd30) begin
            failures++;
            $display("FAIL bs_in_row: we=%b addr=%0d data=%h row=%0d col=%0d, required 1 62 20 1 30",
                     mem_we, mem_addr, mem_data, cursor_row, cursor_col);
        end
        do_reset();
        send_char(8'h08);
        checks++;
        if (mem_we !== 1'b0 || cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL bs_origin: we=%b row=%0d col=%0d, required 0 0 0", mem_we, cursor_row, cursor_col);
        end
    endtask

    task automatic test_last_cell();
        do_reset();
        for (int i = 0; i < 6; i++) send_char(8'h0A);
        for (int i = 0; i < 31; i++) send_char(8'h2E);
        tick();
        checks++;
        if (cursor_row !== 8'd6 || cursor_col !== 8'd31) begin
            failures++;
            $display("FAIL last_setup: row=%0d col=%0d, required 6 31", cursor_row, cursor_col);
        end
        send_char(8'h5A);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd223 || mem_data !== 8'h5A ||
            cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL last_cell: we=%b addr=%0d data=%h row=%0d col=%0d, required 1 223 5a 0 0",
                     mem_we, mem_addr, mem_data, cursor_row, cursor_col);
        end
        // newline on the last row wraps to row 0
        for (int i = 0; i < 6; i++) send_char(8'h0A);
        send_char(8'h0A);
        checks++;
        if (cursor_row !== 8'd0 || cursor_col !== 8'd0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL newline_wrap: row=%0d col=%0d we=%b, required 0 0 0", cursor_row, cursor_col, mem_we);
        end
    endtask

    task automatic test_clear();
        int bad;
        do_reset();
        send_char(8'h41);
        send_char(8'h0A);
        tick();
        bus.clear_req = 1'b1;
        bus.write_req = 1'b1;
        bus.char_in   = 8'h41;
        tick();
        bus.clear_req = 1'b0;
        bus.write_req = 1'b0;
        checks++;
        if (cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL clear_cursor: row=%0d col=%0d, required 0 0", cursor_row, cursor_col);
        end
        bad = 0;
        for (int k = 0; k < 224; k++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 8'(k) || mem_data !== 8'h20 || bus.ready !== 1'b0) begin
                failures++;
                if (bad < 5)
                    $display("FAIL clear_sweep[%0d]: we=%b addr=%0d data=%h ready=%b, required 1 %0d 20 0",
                             k, mem_we, mem_addr, mem_data, bus.ready, k);
                bad++;
            end
            tick();
        end
        checks++;
        if (mem_we !== 1'b0 || bus.ready !== 1'b1 || mem_addr !== 8'd223 || mem_data !== 8'h20 ||
            cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL clear_end: we=%b ready=%b addr=%0d data=%h row=%0d col=%0d, required 0 1 223 20 0 0",
                     mem_we, bus.ready, mem_addr, mem_data, cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        do_reset();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        n = 0;
        while (mem_addr !== 8'd101 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (mem_addr !== 8'd101) begin
            failures++;
            $display("FAIL midclear_reach: addr=%0d after %0d cycles, required 101", mem_addr, n);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_data !== 8'd0 ||
            cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
            failures++;
            $display("FAIL midclear_reset: ready=%b we=%b addr=%0d data=%h row=%0d col=%0d, required 1 0 0 00 0 0",
                     bus.ready, mem_we, mem_addr, mem_data, cursor_row, cursor_col);
        end
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (mem_we !== 1'b0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL midclear_idle: we=%b ready=%b, required 0 1", mem_we, bus.ready);
        end
        send_char(8'h4B);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_data !== 8'h4B ||
            cursor_row !== 8'd0 || cursor_col !== 8'd1) begin
            failures++;
            $display("FAIL midclear_first: we=%b addr=%0d data=%h row=%0d col=%0d, required 1 0 4b 0 1",
                     mem_we, mem_addr, mem_data, cursor_row, cursor_col);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        resetn        = 1'b0;
        bus.write_req = 1'b0;
        bus.clear_req = 1'b0;
        bus.char_in   = 8'h00;
        test_reset();
        test_single_write();
        test_null_char();
        test_wrap();
        test_last_cell();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
